// File: rtl/data_bus_response_router_pkg.sv
// Shared data-bus types: decoded slave codes, router state encoding and the
// read data returned on an error response.
package pixel_riscv_soc_pkg;

   localparam int          N_DATA_SLAVES     = 8;
   localparam int          SLV_W             = 4;
   localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADD_ADD5;

   // DATA_BUS_NONE sits at all-ones so it can never alias a real slave index.
   typedef enum logic [SLV_W-1:0] {
      SLV_BOOT_ROM  = 4'd0,
      SLV_CODE_RAM  = 4'd1,
      SLV_DATA_RAM  = 4'd2,
      SLV_GPIO      = 4'd3,
      SLV_SPI       = 4'd4,
      SLV_UART      = 4'd5,
      SLV_TIMER     = 4'd6,
      SLV_PMC       = 4'd7,
      DATA_BUS_NONE = 4'hF
   } slv_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_RSP = 2'd1,
      ERR_RSP  = 2'd2
   } rtr_state_t;

endpackage

// File: rtl/data_bus_response_router_if.sv
// Core-side request/response and per-slave fan-out signals of the data bus.
// The router uses the slave modport; the core/slave models use master.
interface data_bus_response_router_if
   import pixel_riscv_soc_pkg::*;
#(
   parameter int NUM_SLAVES = N_DATA_SLAVES
);
   logic                       core_req;
   logic [31:0]                core_addr;
   slv_t                       requested_slave;
   logic                       core_gnt;
   logic                       core_rvalid;
   logic [31:0]                core_rdata;
   logic                       core_err;
   logic [NUM_SLAVES-1:0]      slave_req;
   logic [NUM_SLAVES-1:0]      slave_gnt;
   logic [NUM_SLAVES-1:0]      slave_rvalid;
   logic [NUM_SLAVES-1:0][31:0] slave_rdata;

   modport slave (
      input  core_req, core_addr, requested_slave,
      output core_gnt, core_rvalid, core_rdata, core_err,
      output slave_req,
      input  slave_gnt, slave_rvalid, slave_rdata
   );

   modport master (
      output core_req, core_addr, requested_slave,
      input  core_gnt, core_rvalid, core_rdata, core_err,
      input  slave_req,
      output slave_gnt, slave_rvalid, slave_rdata
   );
endinterface

// File: rtl/data_bus_response_router_timeout_counter.sv
// Counts waiting cycles of the outstanding transaction; expired fires in the
// last waiting cycle so the error response lands TIMEOUT_CYCLES after grant.
module data_bus_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expired = enable && !clear && (count == CNT_W'(TIMEOUT_CYCLES - 2));

endmodule

// File: rtl/data_bus_response_router.sv
// Routes one outstanding core data request to the decoded slave, returns its
// response, and synthesises error responses for unmapped or silent slaves.
module data_bus_response_router
   import pixel_riscv_soc_pkg::*;
#(
   parameter int          NUM_SLAVES     = N_DATA_SLAVES,
   parameter int          TIMEOUT_CYCLES = 16,
   parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
   input  logic                        clk,
   input  logic                        rst,
   data_bus_response_router_if.slave   bus,
   output logic                        err_flag,
   output logic [31:0]                 err_addr,
   input  logic                        err_clr
);
   localparam int IDX_W = $clog2(NUM_SLAVES);

   rtr_state_t       state, state_nx;
   logic [IDX_W-1:0] req_idx, lat_idx;
   logic [31:0]      lat_addr;
   logic             req_none, sel_rvalid, can_accept;
   logic             take_slave, take_none, tmo_en, tmo_expired;

   // Any code outside 0..NUM_SLAVES-1 (DATA_BUS_NONE included) is unmapped.
   assign req_idx    = bus.requested_slave[IDX_W-1:0];
   assign req_none   = (bus.requested_slave >= SLV_W'(NUM_SLAVES));
   assign sel_rvalid = (state == WAIT_RSP) && bus.slave_rvalid[lat_idx];
   assign can_accept = !rst && ((state == IDLE) || sel_rvalid);
   assign take_none  = can_accept && bus.core_req && req_none;
   assign take_slave = can_accept && bus.core_req && !req_none && bus.slave_gnt[req_idx];
   assign tmo_en     = (state == WAIT_RSP) && !sel_rvalid;

   data_bus_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (take_slave),
      .enable  (tmo_en),
      .expired (tmo_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // NOTE: each combinational block assigns defaults first so no path can
   // leave an output unassigned and infer a latch.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (take_slave)     state_nx = WAIT_RSP;
            else if (take_none) state_nx = ERR_RSP;
         end
         WAIT_RSP: begin
            if (sel_rvalid) begin
               if (take_slave)     state_nx = WAIT_RSP;
               else if (take_none) state_nx = ERR_RSP;
               else                state_nx = IDLE;
            end else if (tmo_expired) begin
               state_nx = ERR_RSP;
            end
         end
         ERR_RSP: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.slave_req   = '0;
      bus.core_gnt    = take_slave || take_none;
      bus.core_rvalid = 1'b0;
      bus.core_rdata  = '0;
      bus.core_err    = 1'b0;
      if (can_accept && bus.core_req && !req_none) bus.slave_req[req_idx] = 1'b1;
      if (sel_rvalid) begin
         bus.core_rvalid = 1'b1;
         bus.core_rdata  = bus.slave_rdata[lat_idx];
      end else if (state == ERR_RSP) begin
         bus.core_rvalid = 1'b1;
         bus.core_rdata  = ERR_RDATA;
         bus.core_err    = 1'b1;
      end
   end

   // A new error outranks a simultaneous err_clr.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_idx  <= '0;
         lat_addr <= '0;
         err_flag <= 1'b0;
         err_addr <= '0;
      end else begin
         if (take_slave)              lat_idx  <= req_idx;
         if (take_slave || take_none) lat_addr <= bus.core_addr;
         if (state == ERR_RSP) begin
            err_flag <= 1'b1;
            err_addr <= lat_addr;
         end else if (err_clr) begin
            err_flag <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_data_bus_response_router.sv
// Directed scenarios plus randomized traffic checked cycle by cycle against a
// transaction-level model of the router.
module tb_data_bus_response_router;
   import pixel_riscv_soc_pkg::*;

   localparam int          NS   = 8;
   localparam int          TMO  = 16;
   localparam logic [31:0] ERRD = 32'hBADD_ADD5;

   logic        clk = 1'b0;
   logic        rst;
   logic        err_clr;
   logic        err_flag;
   logic [31:0] err_addr;

   int n_total = 0;
   int n_bad   = 0;

   data_bus_response_router_if #(.NUM_SLAVES(NS)) bus();

   data_bus_response_router #(
      .NUM_SLAVES     (NS),
      .TIMEOUT_CYCLES (TMO),
      .ERR_RDATA      (ERRD)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .err_flag (err_flag),
      .err_addr (err_addr),
      .err_clr  (err_clr)
   );

   always #5 clk = ~clk;

   // Transaction-level model: one outstanding slave transaction with its grant
   // cycle, or one pending error response due in a given cycle.
   bit          m_busy, m_err_due, m_flag;
   int          m_slave, m_grant, cyc;
   logic [31:0] m_addr, m_eaddr;

   logic        obs_gnt, obs_rv, obs_err, obs_flag;
   logic [31:0] obs_rd, obs_eaddr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
      end
   endtask

   task automatic idle_inputs();
      bus.core_req        = 1'b0;
      bus.core_addr       = '0;
      bus.requested_slave = DATA_BUS_NONE;
      bus.slave_gnt       = '0;
      bus.slave_rvalid    = '0;
      bus.slave_rdata     = '0;
      err_clr             = 1'b0;
   endtask

   task automatic model_reset();
      m_busy = 0; m_err_due = 0; m_flag = 0;
      m_slave = 0; m_grant = 0;
      m_addr = '0; m_eaddr = '0;
   endtask

   // One clock cycle: compare outputs at the falling edge, advance the model
   // at the rising edge, leave the caller 1 time unit after it to drive inputs.
   task automatic step();
      logic          e_gnt, e_rv, e_err;
      logic [31:0]   e_rd;
      logic [NS-1:0] e_req;
      bit            free, n_busy, n_err_due, n_flag;
      int            n_slave, n_grant, rs;
      logic [31:0]   n_addr, n_eaddr;

      @(negedge clk);
      e_gnt = 0; e_rv = 0; e_err = 0; e_rd = '0; e_req = '0; free = 0;
      n_busy = m_busy; n_err_due = m_err_due; n_flag = m_flag;
      n_slave = m_slave; n_grant = m_grant; n_addr = m_addr; n_eaddr = m_eaddr;

      if (m_err_due) begin
         e_rv = 1; e_err = 1; e_rd = ERRD;
         n_err_due = 0; n_flag = 1; n_eaddr = m_addr;
      end else begin
         if (err_clr) n_flag = 0;
         if (m_busy) begin
            if (bus.slave_rvalid[m_slave]) begin
               e_rv = 1; e_rd = bus.slave_rdata[m_slave];
               n_busy = 0; free = 1;
            end else if (cyc + 1 - m_grant == TMO) begin
               n_busy = 0; n_err_due = 1;
            end
         end else begin
            free = 1;
         end
      end

      rs = int'(bus.requested_slave);
      if (free && bus.core_req) begin
         if (rs >= NS) begin
            e_gnt = 1; n_err_due = 1; n_addr = bus.core_addr;
         end else begin
            e_req[rs] = 1'b1;
            e_gnt = bus.slave_gnt[rs];
            if (e_gnt) begin
               n_busy = 1; n_slave = rs; n_grant = cyc; n_addr = bus.core_addr;
            end
         end
      end

      check("core_gnt",    bus.core_gnt,    e_gnt);
      check("core_rvalid", bus.core_rvalid, e_rv);
      check("core_rdata",  bus.core_rdata,  e_rd);
      check("core_err",    bus.core_err,    e_err);
      check("slave_req",   bus.slave_req,   e_req);
      check("err_flag",    err_flag,        m_flag);
      check("err_addr",    err_addr,        m_eaddr);
      obs_gnt = bus.core_gnt; obs_rv = bus.core_rvalid; obs_rd = bus.core_rdata;
      obs_err = bus.core_err; obs_flag = err_flag; obs_eaddr = err_addr;

      @(posedge clk);
      m_busy = n_busy; m_err_due = n_err_due; m_flag = n_flag;
      m_slave = n_slave; m_grant = n_grant; m_addr = n_addr; m_eaddr = n_eaddr;
      cyc++;
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_gnt"},  bus.core_gnt,    0);
      check({tag, "_rv"},   bus.core_rvalid, 0);
      check({tag, "_rd"},   bus.core_rdata,  0);
      check({tag, "_err"},  bus.core_err,    0);
      check({tag, "_sreq"}, bus.slave_req,   0);
      check({tag, "_flag"}, err_flag,        0);
      check({tag, "_addr"}, err_addr,        0);
   endtask

   task automatic drive_req(input slv_t s, input logic [31:0] a, input bit gnt);
      bus.core_req        = 1'b1;
      bus.core_addr       = a;
      bus.requested_slave = s;
      if (gnt && int'(s) < NS) bus.slave_gnt[int'(s)] = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      rst = 1'b1;
      idle_inputs();
      model_reset();
      cyc = 0;
      #12;
      check_all_zero("reset");
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      // GPIO read with same-cycle grant and next-cycle data
      drive_req(SLV_GPIO, 32'h4000_0010, 1);
      step();
      check("gpio_gnt", obs_gnt, 1);
      idle_inputs();
      bus.slave_rvalid[int'(SLV_GPIO)] = 1'b1;
      bus.slave_rdata[int'(SLV_GPIO)]  = 32'h1234_5678;
      step();
      check("gpio_rdata", obs_rd, 32'h1234_5678);
      check("gpio_err", obs_err, 0);
      idle_inputs();
      step();
      check("gpio_gnt_once", obs_gnt, 0);

      // Unmapped address
      drive_req(DATA_BUS_NONE, 32'hF000_0000, 0);
      step();
      check("unm_gnt", obs_gnt, 1);
      idle_inputs();
      step();
      check("unm_rdata", obs_rd, ERRD);
      check("unm_err", obs_err, 1);
      step();
      check("unm_flag", obs_flag, 1);
      check("unm_addr", obs_eaddr, 32'hF000_0000);

      // Timeout on a silent UART, then a late UART rvalid 20 cycles after grant
      drive_req(SLV_UART, 32'h4002_0000, 1);
      step();
      idle_inputs();
      lat = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (obs_err === 1'b1) begin lat = i; break; end
      end
      check("tmo_latency", lat, TMO);
      for (int i = lat + 1; i <= 20; i++) begin
         if (i == 20) begin
            bus.slave_rvalid[int'(SLV_UART)] = 1'b1;
            bus.slave_rdata[int'(SLV_UART)]  = 32'hDEAD_BEEF;
         end
         step();
      end
      check("late_rvalid", obs_rv, 0);
      check("late_rdata", obs_rd, 0);
      check("tmo_addr", obs_eaddr, 32'h4002_0000);
      idle_inputs();

      // Back-to-back: data RAM response and SPI grant in the same cycle
      drive_req(SLV_DATA_RAM, 32'h2000_0100, 1);
      step();
      idle_inputs();
      bus.slave_rvalid[int'(SLV_DATA_RAM)] = 1'b1;
      bus.slave_rdata[int'(SLV_DATA_RAM)]  = 32'hAAAA_0001;
      drive_req(SLV_SPI, 32'h4001_0000, 1);
      step();
      check("b2b_gnt", obs_gnt, 1);
      check("b2b_rdata1", obs_rd, 32'hAAAA_0001);
      idle_inputs();
      bus.slave_rvalid[int'(SLV_SPI)] = 1'b1;
      bus.slave_rdata[int'(SLV_SPI)]  = 32'h5555_0002;
      step();
      check("b2b_rdata2", obs_rd, 32'h5555_0002);
      idle_inputs();

      // err_clr in the ERR_RSP cycle loses, err_clr alone then clears
      drive_req(DATA_BUS_NONE, 32'hF000_0004, 0);
      step();
      idle_inputs();
      err_clr = 1'b1;
      step();
      check("clr_race_err", obs_err, 1);
      step();
      check("clr_race_flag", obs_flag, 1);
      check("clr_race_addr", obs_eaddr, 32'hF000_0004);
      idle_inputs();
      step();
      check("clr_flag", obs_flag, 0);
      check("clr_addr_kept", obs_eaddr, 32'hF000_0004);

      // Reset while waiting on GPIO; its response arrives during reset
      drive_req(SLV_GPIO, 32'h4000_0020, 1);
      step();
      idle_inputs();
      step();
      bus.slave_rvalid[int'(SLV_GPIO)] = 1'b1;
      bus.slave_rdata[int'(SLV_GPIO)]  = 32'h0BAD_0BAD;
      drive_req(SLV_GPIO, 32'h4000_0024, 1);
      #1 rst = 1'b1;
      #1 check_all_zero("midrst");
      model_reset();
      @(posedge clk); #1;
      idle_inputs();
      rst = 1'b0;
      drive_req(SLV_GPIO, 32'h4000_0030, 1);
      step();
      check("postrst_gnt", obs_gnt, 1);
      idle_inputs();
      bus.slave_rvalid[int'(SLV_GPIO)] = 1'b1;
      bus.slave_rdata[int'(SLV_GPIO)]  = 32'h0000_C0DE;
      step();
      check("postrst_rdata", obs_rd, 32'h0000_C0DE);
      idle_inputs();

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         bus.core_req  = ($urandom_range(0, 9) < 7);
         bus.core_addr = $urandom;
         bus.requested_slave = ($urandom_range(0, 9) == 0) ? DATA_BUS_NONE
                                                            : slv_t'($urandom_range(0, NS - 1));
         bus.slave_gnt = NS'($urandom);
         for (int s = 0; s < NS; s++) begin
            bus.slave_rvalid[s] = ($urandom_range(0, 9) == 0);
            bus.slave_rdata[s]  = $urandom;
         end
         err_clr = ($urandom_range(0, 9) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
